// File: rtl/decrypt_sched.sv
// Job scheduler: queues {sel, data} requests and issues them one at a time to the decryptor demux,
// honouring per-target busy and a fixed post-issue holdoff. Optional drop counter: DECRYPT_SCHED_STATS_EN.
module decrypt_sched #(
    parameter int MST_DWIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLDOFF    = 16
) (
    input  logic                          clk_mst,
    input  logic                          rst_n,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [MST_DWIDTH-1:0]         req_data_i,
    input  logic [1:0]                    req_sel_i,
    input  logic [2:0]                    dec_busy_i,
    output logic [MST_DWIDTH-1:0]         data_o,
    output logic [1:0]                    select_o,
    output logic                          valid_o,
    output logic                          err_o,
`ifdef DECRYPT_SCHED_STATS_EN
    output logic [7:0]                    drop_cnt_o,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [MST_DWIDTH+1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [LW-1:0]           level;

    logic                    accept;
    logic                    bad_req;
    logic                    push;
    logic                    pop;
    logic [MST_DWIDTH+1:0]   head;
    logic [1:0]              head_sel;
    logic [3:0]              busy_ext;

    // Ready depends only on the registered level, never on req_valid_i.
    assign req_ready_o  = (level != LW'(FIFO_DEPTH));
    assign fifo_level_o = level;

    assign accept   = req_valid_i && req_ready_o;
    assign bad_req  = accept && (req_sel_i == 2'd3);
    assign push     = accept && (req_sel_i != 2'd3);
    assign pop      = (state == ISSUE);
    assign head     = mem[rd_ptr];
    assign head_sel = head[MST_DWIDTH+1:MST_DWIDTH];
    // Select 3 never reaches the queue; treat it as permanently busy so indexing stays in range.
    assign busy_ext = {1'b1, dec_busy_i};

    always_ff @(posedge clk_mst) begin
        if (push) begin
            mem[wr_ptr] <= {req_sel_i, req_data_i};
        end
    end

    always_ff @(posedge clk_mst) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_mst) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else begin
            err_o <= bad_req;
        end
    end

`ifdef DECRYPT_SCHED_STATS_EN
    always_ff @(posedge clk_mst) begin
        if (!rst_n) begin
            drop_cnt_o <= 8'd0;
        end else if (bad_req && (drop_cnt_o != 8'hFF)) begin
            drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end
`endif

    // Busy is only looked at in IDLE; the head stays put until its own ISSUE.
    always_ff @(posedge clk_mst) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            select_o <= 2'd0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if ((level != '0) && !busy_ext[head_sel]) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    valid_o  <= 1'b1;
                    data_o   <= head[MST_DWIDTH-1:0];
                    select_o <= head_sel;
                    cnt      <= CW'(HOLDOFF - 1);
                    state    <= HOLD;
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decrypt_sched.sv
// Bench for decrypt_sched: directed scenarios plus random traffic, checked every cycle against a
// timing-rule model (queue of jobs, earliest-issue rule derived from holdoff and busy).
module tb_decrypt_sched;

    localparam int W = 32;
    localparam int D = 4;
    localparam int H = 16;

    logic           clk_mst = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic [W-1:0]   req_data_i = '0;
    logic [1:0]     req_sel_i = 2'd0;
    logic [2:0]     dec_busy_i = 3'd0;
    logic [W-1:0]   data_o;
    logic [1:0]     select_o;
    logic           valid_o;
    logic           err_o;
    logic [$clog2(D):0] fifo_level_o;
`ifdef DECRYPT_SCHED_STATS_EN
    logic [7:0]     drop_cnt_o;
`endif

    always #5 clk_mst = ~clk_mst;

    decrypt_sched #(.MST_DWIDTH(W), .FIFO_DEPTH(D), .HOLDOFF(H)) dut (
        .clk_mst      (clk_mst),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_data_i   (req_data_i),
        .req_sel_i    (req_sel_i),
        .dec_busy_i   (dec_busy_i),
        .data_o       (data_o),
        .select_o     (select_o),
        .valid_o      (valid_o),
        .err_o        (err_o),
`ifdef DECRYPT_SCHED_STATS_EN
        .drop_cnt_o   (drop_cnt_o),
`endif
        .fifo_level_o (fifo_level_o)
    );

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } job_t;

    int n_assert = 0;
    int n_fail   = 0;
    int e        = 0;

    job_t         q[$];
    logic         m_pending = 1'b0;
    int           m_last = -100;
    logic         m_valid = 1'b0;
    logic         m_err = 1'b0;
    logic [W-1:0] m_data = '0;
    logic [1:0]   m_sel = 2'd0;
    int           m_drop = 0;
    int           acc_edge = 0;
    int           err_seen = 0;
    int           vedges[$];
    logic [1:0]   vsels[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a job may be issued (valid seen after edge t) when it is at the head, its target
    // was idle at edge t-1, and t-1 is at least HOLDOFF+1 edges after the previous issue edge.
    task automatic model_edge();
        int sz0;
        if (!rst_n) begin
            q.delete();
            m_pending = 1'b0;
            m_last    = -100;
            m_valid   = 1'b0;
            m_err     = 1'b0;
            m_data    = '0;
            m_sel     = 2'd0;
            m_drop    = 0;
            return;
        end
        sz0     = q.size();
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (m_pending) begin
            m_valid   = 1'b1;
            m_data    = q[0].data;
            m_sel     = q[0].sel;
            void'(q.pop_front());
            m_last    = e;
            m_pending = 1'b0;
        end else if (q.size() > 0 && e >= m_last + H + 1 && dec_busy_i[q[0].sel] == 1'b0) begin
            m_pending = 1'b1;
        end
        if (req_valid_i && sz0 < D) begin
            acc_edge = e;
            if (req_sel_i == 2'd3) begin
                m_err = 1'b1;
                if (m_drop < 255) m_drop++;
            end else begin
                q.push_back('{req_sel_i, req_data_i});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_mst);
        e++;
        model_edge();
        #1;
        if (valid_o === 1'b1) begin
            vedges.push_back(e);
            vsels.push_back(select_o);
        end
        if (err_o === 1'b1) err_seen++;
        check("valid_o", valid_o, m_valid);
        check("data_o", data_o, m_data);
        check("select_o", select_o, m_sel);
        check("err_o", err_o, m_err);
        check("fifo_level_o", fifo_level_o, q.size());
        check("req_ready_o", req_ready_o, q.size() < D);
`ifdef DECRYPT_SCHED_STATS_EN
        check("drop_cnt_o", drop_cnt_o, m_drop);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [1:0] sel, input logic [W-1:0] data);
        req_valid_i = 1'b1;
        req_sel_i   = sel;
        req_data_i  = data;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        idle(n);
        rst_n = 1'b1;
    endtask

    initial begin
        int a;

        do_reset(3);
        check("reset_level", fifo_level_o, 0);
        check("reset_ready", req_ready_o, 1);
        idle(2);

        // Single job latency
        vedges.delete(); vsels.delete();
        push(2'd1, 32'hDEADBEEF);
        a = acc_edge;
        idle(25);
        check("single_count", vedges.size(), 1);
        check("single_latency", (vedges.size() > 0) ? vedges[0] - a : -1, 2);

        // Back-to-back: fill while targets busy, then release
        vedges.delete(); vsels.delete();
        dec_busy_i = 3'b111;
        push(2'd0, $urandom);
        push(2'd1, $urandom);
        push(2'd2, $urandom);
        push(2'd0, $urandom);
        check("full_ready", req_ready_o, 0);
        check("full_level", fifo_level_o, 4);
        dec_busy_i = 3'b000;
        idle(80);
        check("b2b_count", vedges.size(), 4);
        for (int i = 1; i < 4; i++) begin
            check("b2b_gap", (vedges.size() == 4) ? vedges[i] - vedges[i-1] : -1, H + 2);
        end
        check("b2b_order", (vedges.size() == 4) ? {vsels[0], vsels[1], vsels[2], vsels[3]} : 8'hFF, 8'b00_01_10_00);

        // Illegal select
        vedges.delete(); vsels.delete(); err_seen = 0;
        push(2'd3, 32'h12345678);
        idle(20);
        check("illegal_err_pulses", err_seen, 1);
        check("illegal_no_issue", vedges.size(), 0);
        check("illegal_level", fifo_level_o, 0);

        // Busy head blocks the queue
        vedges.delete(); vsels.delete();
        dec_busy_i = 3'b100;
        push(2'd2, 32'hA5A5_0002);
        push(2'd0, 32'hA5A5_0000);
        idle(30);
        check("blocked_no_issue", vedges.size(), 0);
        dec_busy_i = 3'b000;
        idle(50);
        check("blocked_count", vedges.size(), 2);
        check("blocked_order", (vedges.size() == 2) ? {vsels[0], vsels[1]} : 4'hF, 4'b10_00);
        check("blocked_gap", (vedges.size() == 2) ? vedges[1] - vedges[0] : -1, H + 2);

        // Reset in the middle of HOLD
        vedges.delete(); vsels.delete();
        push(2'd1, $urandom);
        push(2'd2, $urandom);
        for (int i = 0; i < 10; i++) begin
            if (vedges.size() > 0) break;
            tick();
        end
        check("midhold_issued", vedges.size(), 1);
        idle(10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vedges.delete();
        idle(40);
        check("midhold_no_issue", vedges.size(), 0);
        check("midhold_level", fifo_level_o, 0);

        // Drop counter saturation
        err_seen = 0;
        repeat (300) push(2'd3, $urandom);
        idle(2);
        check("sat_err_pulses", err_seen, 300);
`ifdef DECRYPT_SCHED_STATS_EN
        check("sat_drop_cnt", drop_cnt_o, 255);
`endif

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            req_valid_i = ($urandom_range(0, 2) != 0);
            req_sel_i   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            req_data_i  = $urandom;
            if ($urandom_range(0, 7) == 0) dec_busy_i = 3'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        req_valid_i = 1'b0;
        rst_n = 1'b1;

        do_reset(2);
        check("final_level", fifo_level_o, 0);
        check("final_valid", valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
